// File: rtl/pwls_bus_pkg.sv
// Shared command type, bus strobe encodings and FSM states for the PWL synth bus sequencer.
// The register shift default matches pwl_synth.vh and only applies when that header is absent.
`ifndef INTERFACE_REGISTER_SHIFT
`define INTERFACE_REGISTER_SHIFT 3
`endif

package pwls_bus_pkg;

    localparam int CMD_BITS_E = 13;

    localparam logic [1:0] BUS_IDLE = 2'b11;
    localparam logic [1:0] BUS_WORD = 2'b10;

    typedef struct packed {
        logic                  read;
        logic [5:0]            addr;
        logic [CMD_BITS_E-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
    } state_t;

endpackage

// File: rtl/pwls_cmd_fifo.sv
// Generic synchronous FIFO with a combinational head, power-of-two depth and an occupancy count.
module pwls_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A full FIFO refuses a push even when a pop lands on the same edge.
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pwls_bus_sequencer.sv
// Buffers host register commands and replays them onto the PWL synth peripheral bus
// with single-cycle write strobes and data_ready-terminated (or timed-out) read strobes.
module pwls_bus_sequencer
    import pwls_bus_pkg::*;
#(
    parameter int BITS_E  = CMD_BITS_E,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic                                       cmd_read,
    input  logic [5:0]                                 cmd_addr,
    input  logic [BITS_E-1:0]                          cmd_wdata,
    output logic                                       rsp_valid,
    output logic [BITS_E-1:0]                          rsp_data,
    output logic                                       rsp_timeout,
    output logic                                       busy,
    output logic [5:0]                                 address,
    output logic [BITS_E+`INTERFACE_REGISTER_SHIFT-1:0] data_in,
    output logic [1:0]                                 data_write_n,
    output logic [1:0]                                 data_read_n,
    input  logic [BITS_E+`INTERFACE_REGISTER_SHIFT-1:0] data_out,
    input  logic                                       data_ready
);

    localparam int SHIFT  = `INTERFACE_REGISTER_SHIFT;
    localparam int DATA_W = BITS_E + SHIFT;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int CMD_W  = $bits(cmd_t);

    state_t               r_state;
    logic [CNT_W-1:0]     r_waitCount;
    cmd_t                 w_pushCmd;
    cmd_t                 w_headCmd;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic [$clog2(DEPTH):0] w_count;

    assign w_pushCmd = '{read: cmd_read, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !w_full && rst_n;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign busy      = (w_count != '0) || (r_state != S_IDLE);

    pwls_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmdFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid && cmd_ready),
        .i_data  (w_pushCmd),
        .i_pop   (w_pop),
        .o_data  (w_headCmd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Only IDLE pops, so every bus op is followed by at least one IDLE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_waitCount  <= '0;
            address      <= '0;
            data_in      <= '0;
            data_write_n <= BUS_IDLE;
            data_read_n  <= BUS_IDLE;
            rsp_valid    <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_data     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        address <= w_headCmd.addr;
                        data_in <= DATA_W'(w_headCmd.wdata) << SHIFT;
                        if (w_headCmd.read) begin
                            r_state     <= S_READ;
                            data_read_n <= BUS_WORD;
                            r_waitCount <= '0;
                        end else begin
                            r_state      <= S_WRITE;
                            data_write_n <= BUS_WORD;
                        end
                    end
                end
                S_WRITE: begin
                    data_write_n <= BUS_IDLE;
                    r_state      <= S_IDLE;
                end
                S_READ: begin
                    if (data_ready) begin
                        rsp_data    <= BITS_E'(data_out >> SHIFT);
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        data_read_n <= BUS_IDLE;
                        r_state     <= S_IDLE;
                    end else if (r_waitCount == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data    <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        data_read_n <= BUS_IDLE;
                        r_state     <= S_IDLE;
                    end else begin
                        r_waitCount <= r_waitCount + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    data_write_n <= BUS_IDLE;
                    data_read_n  <= BUS_IDLE;
                end
            endcase
        end
    end

endmodule
